// File: rtl/result_checker.sv
// result_checker: multi-channel run checker for core regression runs.
// A start latches per-channel expected result/empty values and a cycle
// budget; the block then watches every channel's result, result_empty and
// trap code and reports pass, per-channel failure and budget expiry.
// Optional feature macro: RESULT_CHECKER_EARLY_EXIT_EN (finish a run with
// pass as soon as every channel has matched for two consecutive RUN cycles).
//
// Handshake: start is a level sampled on each clk edge; it is accepted only
// in IDLE or DONE (ignored in RUN). busy is high for exactly the RUN cycles,
// done is high from the end of a run until the next accepted start, and
// pass/fail_mask/timed_out are meaningful only while done is high.
module result_checker #(
    parameter int CHANNELS = 1,
    parameter int DW       = 64,
    parameter int TRAPW    = 4,
    parameter int CW       = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [CW-1:0]             timeout,
    input  logic [CHANNELS*DW-1:0]    exp_result,
    input  logic [CHANNELS-1:0]       exp_empty,
    input  logic [CHANNELS*DW-1:0]    result,
    input  logic [CHANNELS-1:0]       result_empty,
    input  logic [CHANNELS*TRAPW-1:0] trap,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [CHANNELS-1:0]       fail_mask,
    output logic                      timed_out,
    output logic [CW-1:0]             cycles,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [CHANNELS*DW-1:0]    r_exp_result;
    logic [CHANNELS-1:0]       r_exp_empty;
    logic [CW-1:0]             r_budget;
    logic [CW-1:0]             r_cycles;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_pass;
    logic [CHANNELS-1:0]       r_fail_mask;
    logic                      r_timed_out;

    logic [CHANNELS-1:0]       w_match;
    logic [CHANNELS-1:0]       w_trap;
    logic                      w_any_trap;
    logic                      w_all_match;
    logic                      w_budget_hit;
    logic                      w_early;
    logic                      w_accept;
    logic [CW-1:0]             w_cycles_inc;
    logic [CW-1:0]             w_budget_in;

    logic                      w_busy_nxt;
    logic                      w_done_nxt;
    logic                      w_pass_nxt;
    logic [CHANNELS-1:0]       w_fail_mask_nxt;
    logic                      w_timed_out_nxt;
    logic [CW-1:0]             w_cycles_nxt;

    // Per-channel trap and match flags against the latched expectations.
    always_comb begin
        w_match = '0;
        w_trap  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_trap[i]  = |trap[i*TRAPW +: TRAPW];
            w_match[i] = (result[i*DW +: DW] == r_exp_result[i*DW +: DW]) &&
                         (result_empty[i] == r_exp_empty[i]) &&
                         !w_trap[i];
        end
    end

    assign w_any_trap   = |w_trap;
    assign w_all_match  = &w_match;
    assign w_cycles_inc = r_cycles + ONE;
    // The run ends on the edge that brings the count up to the budget.
    assign w_budget_hit = (w_cycles_inc == r_budget);
    assign w_accept     = start && (r_state != S_RUN);
    // A zero budget would never be reached by the counter; treat it as one.
    assign w_budget_in  = (timeout == '0) ? ONE : timeout;

`ifdef RESULT_CHECKER_EARLY_EXIT_EN
    logic r_match_prev;

    // Remembers whether every channel matched on the previous RUN cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_match_prev <= 1'b0;
        end else if (w_accept) begin
            r_match_prev <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_match_prev <= w_all_match;
        end
    end

    assign w_early = w_all_match && r_match_prev;
`else
    assign w_early = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: trap, early exit or budget expiry ends a run.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_any_trap || w_early || w_budget_hit) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered status outputs.
    always_comb begin
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_fail_mask_nxt = r_fail_mask;
        w_timed_out_nxt = r_timed_out;
        w_cycles_nxt    = r_cycles;
        if (w_accept) begin
            w_busy_nxt      = 1'b1;
            w_done_nxt      = 1'b0;
            w_pass_nxt      = 1'b0;
            w_fail_mask_nxt = '0;
            w_timed_out_nxt = 1'b0;
            w_cycles_nxt    = '0;
        end else if (r_state == S_RUN) begin
            w_cycles_nxt = w_cycles_inc;
            if (w_any_trap) begin
                // Trapping channels are non-matching, so ~match covers both.
                w_busy_nxt      = 1'b0;
                w_done_nxt      = 1'b1;
                w_pass_nxt      = 1'b0;
                w_fail_mask_nxt = ~w_match;
                w_timed_out_nxt = 1'b0;
            end else if (w_early) begin
                w_busy_nxt      = 1'b0;
                w_done_nxt      = 1'b1;
                w_pass_nxt      = 1'b1;
                w_fail_mask_nxt = '0;
                w_timed_out_nxt = 1'b0;
            end else if (w_budget_hit) begin
                w_busy_nxt      = 1'b0;
                w_done_nxt      = 1'b1;
                w_pass_nxt      = w_all_match;
                w_fail_mask_nxt = ~w_match;
                w_timed_out_nxt = 1'b1;
            end
        end
    end

    // Status registers and latched expectations.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_exp_result <= '0;
            r_exp_empty  <= '0;
            r_budget     <= '0;
            r_cycles     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_mask  <= '0;
            r_timed_out  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_exp_result <= exp_result;
                r_exp_empty  <= exp_empty;
                r_budget     <= w_budget_in;
            end
            r_cycles    <= w_cycles_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_mask <= w_fail_mask_nxt;
            r_timed_out <= w_timed_out_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail_mask;
    assign timed_out = r_timed_out;
    assign cycles    = r_cycles;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker with two channels of 64-bit results.
module tb_result_checker;

    localparam int CHANNELS = 2;
    localparam int DW       = 64;
    localparam int TRAPW    = 4;
    localparam int CW       = 16;

`ifdef RESULT_CHECKER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic                      clk;
    logic                      reset_n;
    logic                      start;
    logic [CW-1:0]             timeout;
    logic [CHANNELS*DW-1:0]    exp_result;
    logic [CHANNELS-1:0]       exp_empty;
    logic [CHANNELS*DW-1:0]    result;
    logic [CHANNELS-1:0]       result_empty;
    logic [CHANNELS*TRAPW-1:0] trap;
    logic                      busy;
    logic                      done;
    logic                      pass;
    logic [CHANNELS-1:0]       fail_mask;
    logic                      timed_out;
    logic [CW-1:0]             cycles;
    logic [1:0]                dbg_state;

    int n_checks;
    int n_pass;
    int n;

    result_checker #(
        .CHANNELS(CHANNELS), .DW(DW), .TRAPW(TRAPW), .CW(CW)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .timeout(timeout),
        .exp_result(exp_result), .exp_empty(exp_empty), .result(result),
        .result_empty(result_empty), .trap(trap), .busy(busy), .done(done),
        .pass(pass), .fail_mask(fail_mask), .timed_out(timed_out),
        .cycles(cycles), .dbg_state(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock edge, then settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a run on the next edge; returns 1ns after that edge.
    task automatic begin_run(input logic [CW-1:0] to);
        start   = 1'b1;
        timeout = to;
        step();
        start   = 1'b0;
    endtask

    // Advance until done, counting edges into n; bounded by limit.
    task automatic wait_done(input int limit, inout int cnt);
        int k;
        k = 0;
        while (done !== 1'b1 && k < limit) begin
            step();
            cnt++;
            k++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        timeout      = '0;
        exp_result   = '0;
        exp_empty    = '0;
        result       = '0;
        result_empty = '0;
        trap         = '0;
        #23;
        reset_n = 1'b1;
        step();

        // reset state
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_pass", {63'd0, pass}, 64'd0);
        check("rst_fail", {62'd0, fail_mask}, 64'd0);
        check("rst_to", {63'd0, timed_out}, 64'd0);
        check("rst_cyc", {48'd0, cycles}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, 64'd0);

        // 1: all channels correct from cycle 3, budget 12
        exp_result = {64'd1, 64'd1};
        exp_empty  = 2'b00;
        result     = '0;
        begin_run(16'd12);
        check("t1_busy", {63'd0, busy}, 64'd1);
        check("t1_state", {62'd0, dbg_state}, 64'd1);
        n = 0;
        step(); n++;
        step(); n++;
        result = {64'd1, 64'd1};
        wait_done(40, n);
        check("t1_lat", n, EE ? 64'd4 : 64'd12);
        check("t1_pass", {63'd0, pass}, 64'd1);
        check("t1_fail", {62'd0, fail_mask}, 64'd0);
        check("t1_to", {63'd0, timed_out}, EE ? 64'd0 : 64'd1);
        check("t1_cyc", {48'd0, cycles}, EE ? 64'd4 : 64'd12);
        check("t1_busy_end", {63'd0, busy}, 64'd0);
        step();
        check("t1_done_hold", {63'd0, done}, 64'd1);

        // 2: channel 1 wrong, budget 8; start from DONE clears status
        exp_result = {64'd1, 64'd7};
        result     = {64'd0, 64'd7};
        begin_run(16'd8);
        check("t2_done_clr", {63'd0, done}, 64'd0);
        check("t2_pass_clr", {63'd0, pass}, 64'd0);
        n = 0;
        wait_done(40, n);
        check("t2_lat", n, 64'd8);
        check("t2_pass", {63'd0, pass}, 64'd0);
        check("t2_fail", {62'd0, fail_mask}, 64'd2);
        check("t2_to", {63'd0, timed_out}, 64'd1);
        check("t2_cyc", {48'd0, cycles}, 64'd8);

        // 3: trap on channel 0 in RUN cycle 5; channel 1 also wrong
        exp_result = {64'd5, 64'd9};
        result     = {64'd0, 64'd9};
        begin_run(16'd100);
        for (int i = 0; i < 4; i++) step();
        check("t3_mid_cyc", {48'd0, cycles}, 64'd4);
        check("t3_mid_done", {63'd0, done}, 64'd0);
        trap = 8'h03;
        step();
        trap = '0;
        check("t3_done", {63'd0, done}, 64'd1);
        check("t3_cyc", {48'd0, cycles}, 64'd5);
        check("t3_fail", {62'd0, fail_mask}, 64'd3);
        check("t3_pass", {63'd0, pass}, 64'd0);
        check("t3_to", {63'd0, timed_out}, 64'd0);

        // 4: asynchronous reset mid-run, then a clean re-run
        exp_result = {64'd2, 64'd3};
        result     = {64'd0, 64'd0};
        begin_run(16'd100);
        for (int i = 0; i < 5; i++) step();
        #2 reset_n = 1'b0;
        #1;
        check("t4_busy", {63'd0, busy}, 64'd0);
        check("t4_cyc", {48'd0, cycles}, 64'd0);
        check("t4_state", {62'd0, dbg_state}, 64'd0);
        check("t4_done", {63'd0, done}, 64'd0);
        #2 reset_n = 1'b1;
        step();
        check("t4_idle", {62'd0, dbg_state}, 64'd0);
        result = {64'd2, 64'd3};
        begin_run(16'd3);
        n = 0;
        wait_done(40, n);
        check("t4_lat", n, EE ? 64'd2 : 64'd3);
        check("t4_pass", {63'd0, pass}, 64'd1);

        // 5: zero budget behaves as one cycle
        begin_run(16'd0);
        check("t5_busy", {63'd0, busy}, 64'd1);
        n = 0;
        wait_done(10, n);
        check("t5_lat", n, 64'd1);
        check("t5_cyc", {48'd0, cycles}, 64'd1);
        check("t5_to", {63'd0, timed_out}, 64'd1);

        // 5b: start pulsed during RUN is ignored (no relatch of budget)
        exp_result = {64'd4, 64'd4};
        result     = {64'd0, 64'd4};
        begin_run(16'd10);
        step(); step(); step();
        begin_run(16'd2);
        check("t5b_cyc", {48'd0, cycles}, 64'd4);
        n = 4;
        wait_done(40, n);
        check("t5b_lat", n, 64'd10);
        check("t5b_cyc_end", {48'd0, cycles}, 64'd10);
        check("t5b_fail", {62'd0, fail_mask}, 64'd2);

        // 6: result_empty differs on channel 0 with equal result
        exp_result   = {64'hA5, 64'h5A};
        result       = {64'hA5, 64'h5A};
        exp_empty    = 2'b00;
        result_empty = 2'b01;
        begin_run(16'd4);
        n = 0;
        wait_done(40, n);
        check("t6_lat", n, 64'd4);
        check("t6_pass", {63'd0, pass}, 64'd0);
        check("t6_fail", {62'd0, fail_mask}, 64'd1);
        check("t6_to", {63'd0, timed_out}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
